conv_layer_sequencer: RTL and testbench

//  Central sequencer for one P=1 convolution layer (x buffer, f ROM, MAC).

---
 rtl/conv_layer_sequencer.sv | 108 ++++++++++
 tb/tb_conv_layer_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sequencer
// Purpose  : Control sequencer for one P=1 convolution layer: loads the x
//            buffer, walks filter taps per output, hands off each finished y.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter int ADDRX = 5,
    parameter int ADDRF = 4,
    parameter int LENX  = 32,
    parameter int LENF  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic             wr_en_x,
    output logic [ADDRX-1:0] addr_x,
    output logic [ADDRF-1:0] addr_f,
    output logic             clr_acc,
    output logic             en_acc,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    localparam int SIZE = LENX - LENF + 1;

    localparam logic [ADDRX-1:0] WPTR_LAST = ADDRX'(LENX - 1);
    localparam logic [ADDRF-1:0] K_LAST    = ADDRF'(LENF - 1);
    localparam logic [ADDRX-1:0] OIDX_LAST = ADDRX'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    state_t           state_q;
    logic [ADDRX-1:0] wptr_q;
    logic [ADDRX-1:0] oidx_q;
    logic [ADDRF-1:0] k_q;
    logic             en_dly_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            wptr_q   <= '0;
            oidx_q   <= '0;
            k_q      <= '0;
            en_dly_q <= 1'b0;
        end else begin
            // Reads have one cycle of latency, so the MAC enable trails COMPUTE by one edge.
            en_dly_q <= (state_q == ST_COMPUTE);
            case (state_q)
                ST_LOAD: begin
                    if (s_valid_x) begin
                        if (wptr_q == WPTR_LAST) begin
                            wptr_q  <= '0;
                            k_q     <= '0;
                            oidx_q  <= '0;
                            state_q <= ST_COMPUTE;
                        end else begin
                            wptr_q <= wptr_q + ADDRX'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (k_q == K_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        k_q <= k_q + ADDRF'(1);
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (m_ready_y) begin
                        if (oidx_q == OIDX_LAST) begin
                            oidx_q  <= '0;
                            state_q <= ST_LOAD;
                        end else begin
                            oidx_q  <= oidx_q + ADDRX'(1);
                            k_q     <= '0;
                            state_q <= ST_COMPUTE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    // Ready is qualified by reset so nothing is accepted while reset is held.
    assign s_ready_x = reset & (state_q == ST_LOAD);
    assign wr_en_x   = s_valid_x & s_ready_x;
    assign addr_x    = (state_q == ST_LOAD) ? wptr_q : (oidx_q + ADDRX'(k_q));
    assign addr_f    = (state_q == ST_COMPUTE) ? k_q : '0;
    assign clr_acc   = (state_q == ST_COMPUTE) && (k_q == '0);
    assign en_acc    = en_dly_q;
    assign m_valid_y = (state_q == ST_OUTPUT);

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_sequencer
// Purpose  : Self-checking bench with x buffer, filter ROM and MAC models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int ADDRX = 5;
    localparam int ADDRF = 4;
    localparam int LENX  = 32;
    localparam int LENF  = 9;
    localparam int SIZE  = LENX - LENF + 1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             s_valid_x = 1'b0;
    logic             m_ready_y = 1'b0;
    logic             s_ready_x;
    logic             wr_en_x;
    logic [ADDRX-1:0] addr_x;
    logic [ADDRF-1:0] addr_f;
    logic             clr_acc;
    logic             en_acc;
    logic             m_valid_y;

    int n_tests = 0;
    int n_fail  = 0;

    int f_rom [LENF] = '{139, -16, 100, -251, -221, 70, 20, -1, 15};
    int x_mem [LENX];
    int xs    [LENX];
    int x_rd;
    int f_rd;
    int acc;
    int x_wdata;

    conv_layer_sequencer #(
        .ADDRX (ADDRX),
        .ADDRF (ADDRF),
        .LENX  (LENX),
        .LENF  (LENF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .wr_en_x   (wr_en_x),
        .addr_x    (addr_x),
        .addr_f    (addr_f),
        .clr_acc   (clr_acc),
        .en_acc    (en_acc),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y)
    );

    always #5 clk = ~clk;

    // Datapath around the sequencer: x buffer, filter ROM, accumulator.
    always @(posedge clk) begin
        x_rd <= x_mem[addr_x];
        f_rd <= (int'(addr_f) < LENF) ? f_rom[addr_f] : 0;
        if (wr_en_x) x_mem[addr_x] <= x_wdata;
        if (clr_acc)     acc <= 0;
        else if (en_acc) acc <= acc + x_rd * f_rd;
    end

    function automatic int ref_y(input int o);
        int s = 0;
        for (int k = 0; k < LENF; k++) s += xs[o + k] * f_rom[k];
        return s;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, int'(s_ready_x), 0);
        check_eq({tag, "_wr"},    int'(wr_en_x),   0);
        check_eq({tag, "_addrx"}, int'(addr_x),    0);
        check_eq({tag, "_addrf"}, int'(addr_f),    0);
        check_eq({tag, "_clr"},   int'(clr_acc),   0);
        check_eq({tag, "_en"},    int'(en_acc),    0);
        check_eq({tag, "_valid"}, int'(m_valid_y), 0);
    endtask

    // One frame: load LENX samples, then collect SIZE outputs.
    task automatic run_frame(input bit rand_valid, input bit pulse, input int stall_o,
                             input int abort_o, input bit check_len);
        int accepted  = 0;
        int guard     = 0;
        int frame_cyc = 0;
        int cycles, en_cnt, clr_cnt, held;

        while (accepted < LENX && guard < 2000) begin
            @(negedge clk);
            s_valid_x = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_ready_y = 1'($urandom_range(0, 1));
            x_wdata   = xs[accepted];
            #1;
            frame_cyc++;
            check_eq("load_ready", int'(s_ready_x), 1);
            check_eq("load_wr",    int'(wr_en_x),   int'(s_valid_x));
            check_eq("load_addr",  int'(addr_x),    accepted);
            if (wr_en_x) accepted++;
            guard++;
        end
        if (accepted != LENX) begin
            check_eq("load_timeout", accepted, LENX);
            return;
        end

        for (int o = 0; o < SIZE; o++) begin
            cycles  = 0;
            en_cnt  = 0;
            clr_cnt = 0;
            guard   = 0;
            while (guard < 50) begin
                @(negedge clk);
                s_valid_x = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
                m_ready_y = 1'($urandom_range(0, 1));
                #1;
                frame_cyc++;
                guard++;
                if (m_valid_y) break;
                check_eq("busy_no_write", int'({s_ready_x, wr_en_x}), 0);
                if (clr_acc) begin
                    clr_cnt++;
                    check_eq("clr_addrx", int'(addr_x), o);
                    check_eq("clr_addrf", int'(addr_f), 0);
                    check_eq("clr_en",    int'(en_acc), 0);
                end
                if (en_acc) en_cnt++;
                if (o == abort_o && cycles == 4) begin
                    reset = 1'b0;
                    #1;
                    check_all_zero("abort");
                    repeat (3) @(negedge clk);
                    s_valid_x = 1'b0;
                    m_ready_y = 1'b0;
                    reset     = 1'b1;
                    #1;
                    check_eq("rel_ready", int'(s_ready_x), 1);
                    check_eq("rel_addrx", int'(addr_x),    0);
                    check_eq("rel_valid", int'(m_valid_y), 0);
                    return;
                end
                cycles++;
            end
            if (!m_valid_y) begin
                check_eq("valid_timeout", int'(m_valid_y), 1);
                return;
            end
            check_eq("latency",   cycles,       LENF + 1);
            check_eq("en_cycles", en_cnt,       LENF);
            check_eq("clr_count", clr_cnt,      1);
            check_eq("out_en",    int'(en_acc), 0);
            check_eq("y_value",   acc,          ref_y(o));

            m_ready_y = (o == stall_o) ? 1'b0 : 1'b1;
            if (o == stall_o) begin
                held = acc;
                repeat (5) begin
                    @(negedge clk);
                    s_valid_x = 1'($urandom_range(0, 1));
                    m_ready_y = 1'b0;
                    #1;
                    frame_cyc++;
                    check_eq("stall_valid", int'(m_valid_y), 1);
                    check_eq("stall_en",    int'(en_acc),    0);
                    check_eq("stall_wr",    int'(wr_en_x),   0);
                    check_eq("stall_y",     acc,             held);
                end
                @(negedge clk);
                m_ready_y = 1'b1;
                #1;
                frame_cyc++;
                check_eq("stall_end_valid", int'(m_valid_y), 1);
            end
        end

        @(negedge clk);
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        #1;
        check_eq("reload_ready", int'(s_ready_x), 1);
        check_eq("reload_valid", int'(m_valid_y), 0);
        if (check_len) check_eq("frame_cycles", frame_cyc, LENX + SIZE * (LENF + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        s_valid_x = 1'b1;
        m_ready_y = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        #1;
        check_eq("post_rst_ready", int'(s_ready_x), 1);
        check_eq("post_rst_addrx", int'(addr_x),    0);

        for (int i = 0; i < LENX; i++) xs[i] = i;
        run_frame(1'b0, 1'b0, -1, -1, 1'b1);

        for (int i = 0; i < LENX; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
        run_frame(1'b1, 1'b1, 3, -1, 1'b0);

        for (int i = 0; i < LENX; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
        run_frame(1'b1, 1'b0, -1, 10, 1'b0);

        for (int i = 0; i < LENX; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
        run_frame(1'b0, 1'b0, -1, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
